// File: rtl/proc_host_seq.sv
// Host-side job sequencer for the processor req/done handshake.
// It loads an operand window into data memory from a byte stream, pulses req,
// waits for done (bounded by a timeout), then streams a result window back out.
// The processor core may use data memory only while this block sits in RUN.
module proc_host_seq #(
    parameter int AW      = 8,
    parameter int LD_BASE = 0,
    parameter int LD_LEN  = 64,
    parameter int RS_BASE = 64,
    parameter int RS_LEN  = 32,
    parameter int TMO     = 4096,
    parameter int TW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic          req,
    input  logic          done,
    output logic          rs_valid,
    output logic [7:0]    rs_data,
    input  logic          rs_ready,
    output logic          busy,
    output logic          timeout
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_REQ       = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_DRAIN_RA  = 3'd4;
    localparam logic [2:0] S_DRAIN_RD  = 3'd5;
    localparam logic [2:0] S_DRAIN_OUT = 3'd6;

    // Window bases and last indices reduced to address width; addresses wrap.
    localparam logic [AW-1:0] LD_FIRST = AW'(LD_BASE);
    localparam logic [AW-1:0] RS_FIRST = AW'(RS_BASE);
    localparam logic [AW-1:0] LD_LAST  = AW'(LD_LEN - 1);
    localparam logic [AW-1:0] RS_LAST  = AW'(RS_LEN - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [AW-1:0] idx;
    logic [TW-1:0] tmo_cnt;
    logic [AW-1:0] addr_q;
    logic [7:0]    wdata_q;
    logic [AW-1:0] ld_addr;
    logic [AW-1:0] rs_addr;
    logic          ld_hs;
    logic          rs_acc;

    // Handshake qualifiers and window addresses; a reset cycle never writes.
    always_comb begin
        ld_hs   = ld_valid && ld_ready && (state == S_LOAD) && !reset;
        rs_acc  = rs_valid && rs_ready && (state == S_DRAIN_OUT);
        ld_addr = LD_FIRST + idx;
        rs_addr = RS_FIRST + idx;
    end

    // Memory port: the write and its address appear in the handshake cycle,
    // the read address is issued in DRAIN_RA, otherwise the last value holds.
    always_comb begin
        mem_we    = ld_hs;
        mem_wdata = ld_hs ? ld_data : wdata_q;
        if (ld_hs) begin
            mem_addr = ld_addr;
        end else if (state == S_DRAIN_RA && !reset) begin
            mem_addr = rs_addr;
        end else begin
            mem_addr = addr_q;
        end
    end

    // Next-state decode of the job sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (ld_hs && idx == LD_LAST) state_nxt = S_REQ;
            end
            S_REQ: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (done) begin
                    state_nxt = S_DRAIN_RA;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN_RA: begin
                state_nxt = S_DRAIN_RD;
            end
            S_DRAIN_RD: begin
                state_nxt = S_DRAIN_OUT;
            end
            S_DRAIN_OUT: begin
                if (rs_acc) state_nxt = (idx == RS_LAST) ? S_IDLE : S_DRAIN_RA;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; the strobes decode the next state
    // so they line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            tmo_cnt  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ld_ready <= 1'b0;
            req      <= 1'b0;
            rs_valid <= 1'b0;
            rs_data  <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            busy     <= (state_nxt != S_IDLE);
            ld_ready <= (state_nxt == S_LOAD);
            req      <= (state_nxt == S_REQ);
            rs_valid <= (state_nxt == S_DRAIN_OUT);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx     <= '0;
                        timeout <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_hs) begin
                        addr_q  <= ld_addr;
                        wdata_q <= ld_data;
                        idx     <= idx + 1'b1;
                    end
                end
                S_REQ: begin
                    tmo_cnt <= '0;
                end
                S_RUN: begin
                    if (done) begin
                        idx <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        timeout <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DRAIN_RA: begin
                    addr_q <= rs_addr;
                end
                S_DRAIN_RD: begin
                    rs_data <= mem_rdata;
                end
                S_DRAIN_OUT: begin
                    if (rs_acc && idx != RS_LAST) idx <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_proc_host_seq.sv
// Scoreboard bench for proc_host_seq: stimulus pushes expected writes, req
// tokens and result bytes; a monitor pops and compares them as they appear.
module tb_proc_host_seq;

    localparam int AW      = 8;
    localparam int LD_LEN  = 4;
    localparam int RS_LEN  = 2;
    localparam int RS_BASE = 64;
    localparam int TMO     = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_ready;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;
    logic          req;
    logic          done = 1'b0;
    logic          rs_valid;
    logic [7:0]    rs_data;
    logic          rs_ready = 1'b1;
    logic          busy;
    logic          timeout;

    proc_host_seq #(
        .AW(AW), .LD_BASE(0), .LD_LEN(LD_LEN), .RS_BASE(RS_BASE),
        .RS_LEN(RS_LEN), .TMO(TMO), .TW(16)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .req(req), .done(done),
        .rs_valid(rs_valid), .rs_data(rs_data), .rs_ready(rs_ready),
        .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory model with synchronous read and a bench preset port.
    logic [7:0]    mem [256];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [7:0]    pre_data = 8'h00;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] rs_q[$];
    int         req_q[$];
    int         wr_cycles[$];
    int         last_wr_cyc = 0;
    int         last_acc_cyc = 0;
    int         prev_acc_cyc = 0;
    int         acc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected writes, req tokens and result bytes.
    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", {24'h0, mem_addr}, {24'h0, e.addr});
                chk("wr_data", {24'h0, mem_wdata}, {24'h0, e.data});
            end
            last_wr_cyc = cyc;
            wr_cycles.push_back(cyc);
        end
        if (req) begin
            if (req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected: got req=1 at cycle %0d expected 0", cyc);
            end else begin
                void'(req_q.pop_front());
                chk("req_cycle", cyc, last_wr_cyc + 1);
            end
        end
        if (rs_valid && rs_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rs_unexpected: got rs_valid=1 data %0h expected 0", rs_data);
        end else if (rs_valid && rs_ready) begin
            chk("rs_data", {24'h0, rs_data}, {24'h0, rs_q.pop_front()});
            prev_acc_cyc = last_acc_cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preset(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] a, input logic [7:0] d);
        int k;
        wr_q.push_back({a, d});
        ld_valid = 1'b1;
        ld_data  = d;
        k = 0;
        while (!ld_ready && k < 50) begin tick(); k++; end
        if (!ld_ready) begin
            checks++; errors++;
            $display("FAIL ld_ready_wait: got ld_ready=0 after %0d cycles expected 1", k);
        end
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("ld_ready_in_load", ld_ready, 1);
        chk("timeout_cleared", timeout, 0);
    endtask

    // One complete job: load four bytes, then either drain or time out.
    task automatic do_job(input logic [31:0] bytes, input int gap, input bit give_done,
                          input logic [7:0] e0, input logic [7:0] e1, input int stall);
        int k;
        int r;
        int acc0;
        wr_cycles.delete();
        rs_ready = (stall == 0);
        pulse_start();
        req_q.push_back(1);
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(i), bytes[8*i +: 8]);
            if (i < 3) repeat (gap) tick();
        end
        chk("wr_count", wr_cycles.size(), 4);
        if (wr_cycles.size() == 4)
            chk("wr_spacing", wr_cycles[3] - wr_cycles[0], 3 * (1 + gap));
        k = 0;
        while (!req && k < 20) begin tick(); k++; end
        chk("req_seen", req, 1);
        r = cyc;
        if (give_done) begin
            rs_q.push_back(e0);
            rs_q.push_back(e1);
            acc0 = acc_cnt;
            repeat (10) tick();
            done = 1'b1;
            k = 0;
            while (!rs_valid && k < 50) begin tick(); k++; end
            done = 1'b0;
            chk("rs_valid_seen", rs_valid, 1);
            for (int s = 0; s < stall; s++) begin
                chk("stall_valid", rs_valid, 1);
                chk("stall_data", {24'h0, rs_data}, {24'h0, e0});
                chk("stall_addr", {24'h0, mem_addr}, RS_BASE);
                chk("stall_timeout", timeout, 0);
                tick();
            end
            rs_ready = 1'b1;
            k = 0;
            while (acc_cnt < acc0 + 2 && k < 50) begin tick(); k++; end
            chk("acc_count", acc_cnt - acc0, 2);
            chk("acc_spacing", last_acc_cyc - prev_acc_cyc, 3);
            chk("busy_drop_cycle", cyc, last_acc_cyc + 1);
            chk("busy_after_drain", busy, 0);
            chk("timeout_after_drain", timeout, 0);
        end else begin
            k = 0;
            while (busy && k < 100) begin tick(); k++; end
            chk("tmo_exit_cycle", cyc - r, 17);
            chk("timeout_set", timeout, 1);
            chk("rs_valid_after_tmo", rs_valid, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_req", req, 0);
        chk("rst_rs_valid", rs_valid, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", {24'h0, mem_addr}, 0);

        // Back-to-back load, done 10 cycles after req, free-running drain.
        preset(8'd64, 8'hA5);
        preset(8'd65, 8'h5A);
        do_job(32'h44332211, 0, 1'b1, 8'hA5, 8'h5A, 0);
        repeat (2) tick();

        // Gapped load and a result stall of 5 cycles on the first byte.
        preset(8'd64, 8'h3C);
        preset(8'd65, 8'hC3);
        do_job(32'h0D0C0B0A, 2, 1'b1, 8'h3C, 8'hC3, 5);
        repeat (2) tick();

        // No done: timeout after TMO cycles in RUN, no drain.
        do_job(32'h99887766, 0, 1'b0, 8'h00, 8'h00, 0);
        repeat (2) tick();

        // Reset in the middle of LOAD after two bytes; start clears timeout.
        pulse_start();
        send_byte(8'd0, 8'hF1);
        send_byte(8'd1, 8'hF2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_busy", busy, 0);
        chk("mid_ld_ready", ld_ready, 0);
        chk("mid_req", req, 0);
        chk("mid_rs_valid", rs_valid, 0);
        chk("mid_timeout", timeout, 0);
        chk("mid_mem_we", mem_we, 0);
        chk("mid_mem_addr", {24'h0, mem_addr}, 0);
        chk("mid_mem_wdata", {24'h0, mem_wdata}, 0);
        chk("mid_rs_data", {24'h0, rs_data}, 0);
        repeat (3) tick();
        chk("mid_no_req", req, 0);

        // Fresh job reloads from the start of the window.
        preset(8'd64, 8'h77);
        preset(8'd65, 8'h88);
        do_job(32'hEFBEADDE, 0, 1'b1, 8'h77, 8'h88, 0);
        repeat (3) tick();

        chk("wr_q_empty", wr_q.size(), 0);
        chk("rs_q_empty", rs_q.size(), 0);
        chk("req_q_empty", req_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
